// File: rtl/cp0_issue_queue_if.sv
// Handshake bundle for the CP0 issue queue: decode-side enqueue, writeback broadcast,
// and the issued-request channel toward CP0.
interface cp0_issue_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TAG_W  = 6
) ();
  logic              enq_valid;
  logic              enq_ready;
  logic              enq_read;
  logic              enq_write;
  logic [ADDR_W-1:0] enq_addr;
  logic              enq_is_ref;
  logic [DATA_W-1:0] enq_data;
  logic [TAG_W-1:0]  enq_dst;

  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;

  logic              cp0_valid;
  logic              cp0_ready;
  logic              cp0_read;
  logic              cp0_write;
  logic [ADDR_W-1:0] cp0_addr;
  logic [DATA_W-1:0] cp0_wdata;
  logic [TAG_W-1:0]  cp0_dst;

  modport master (
    output enq_valid, enq_read, enq_write, enq_addr, enq_is_ref, enq_data, enq_dst,
    output wb_valid, wb_tag, wb_data, cp0_ready,
    input  enq_ready, cp0_valid, cp0_read, cp0_write, cp0_addr, cp0_wdata, cp0_dst
  );

  modport slave (
    input  enq_valid, enq_read, enq_write, enq_addr, enq_is_ref, enq_data, enq_dst,
    input  wb_valid, wb_tag, wb_data, cp0_ready,
    output enq_ready, cp0_valid, cp0_read, cp0_write, cp0_addr, cp0_wdata, cp0_dst
  );
endinterface

// File: rtl/cp0_issue_queue.sv
// In-order CP0 request queue: MTC0 sources may wait on a rename tag, captured from the
// writeback broadcast; the head issues only once its operand is present.
module cp0_issue_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TAG_W  = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  cp0_issue_queue_if.slave             bus_io,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d, pend_q, pend_d;
  logic [DEPTH-1:0]  rd_q, wr_q, wake;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [TAG_W-1:0]  dst_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              push, pop, bypass, issue, new_pend;
  logic [DATA_W-1:0] new_data;
  logic [TAG_W-1:0]  new_dst;

  always_comb begin
    bus_io.enq_ready = (count_q < CntW'(DEPTH));
    // A handshake with both or neither op bit is consumed but never stored.
    push   = bus_io.enq_valid & bus_io.enq_ready & ~flush_i &
             (bus_io.enq_read ^ bus_io.enq_write);
    bypass = bus_io.wb_valid & (bus_io.wb_tag == bus_io.enq_data[TAG_W-1:0]);
    issue  = (count_q != '0) & ~pend_q[head_q];
    pop    = issue & bus_io.cp0_ready & ~flush_i;

    new_pend = bus_io.enq_write & bus_io.enq_is_ref & ~bypass;
    new_dst  = bus_io.enq_read ? bus_io.enq_dst : '0;
    new_data = '0;
    if (bus_io.enq_write) begin
      if (!bus_io.enq_is_ref)  new_data = bus_io.enq_data;
      else if (bypass)         new_data = bus_io.wb_data;
      else                     new_data = DATA_W'(bus_io.enq_data[TAG_W-1:0]);
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      wake[i] = bus_io.wb_valid & valid_q[i] & pend_q[i] &
                (data_q[i][TAG_W-1:0] == bus_io.wb_tag);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CntW'(push) - CntW'(pop);
    valid_d = valid_q;
    pend_d  = pend_q & ~wake;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      pend_d[tail_q]  = new_pend;
      tail_d          = tail_q + PtrW'(1);
    end
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      pend_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      pend_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  // Payload storage needs no reset: valid_q/pend_q gate every use of it.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && tail_q == PtrW'(i)) begin
        rd_q[i]   <= bus_io.enq_read;
        wr_q[i]   <= bus_io.enq_write;
        addr_q[i] <= bus_io.enq_addr;
        dst_q[i]  <= new_dst;
        data_q[i] <= new_data;
      end else if (wake[i] && !flush_i) begin
        data_q[i] <= bus_io.wb_data;
      end
    end
  end

  always_comb begin
    bus_io.cp0_valid = issue;
    bus_io.cp0_read  = issue & rd_q[head_q];
    bus_io.cp0_write = issue & wr_q[head_q];
    bus_io.cp0_addr  = issue ? addr_q[head_q] : '0;
    bus_io.cp0_wdata = issue ? data_q[head_q] : '0;
    bus_io.cp0_dst   = issue ? dst_q[head_q]  : '0;
    count_o          = count_q;
  end
endmodule
